usr_command_sequencer: RTL
==========================

# usr_command_sequencer

Command-driven controller sitting directly upstream of the 4-bit universal shift register. It accepts one command at a time over a valid/ready handshake and drives the register's `sel`, `serial_in_right`, `serial_in_left` and `parallel_in` inputs cycle by cycle. Supported operations are load, multi-step shift, rotate and arithmetic shift, with a one-cycle `done` pulse when each command completes. It reads the register's output `q` back to generate rotate and arithmetic-shift feedback.

## Interface
- COUNT_W, 3, width of the shift-count field; maximum count is 2^COUNT_W-1.
- clk  in  1  rising-edge clock, shared with the shift register.
- clear  in  1  synchronous active-high reset, shared with the shift register's `clear`.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110 ASR, 111 illegal.
- cmd_count  in  COUNT_W  number of shift steps.
- cmd_data  in  4  load value for LOAD.
- cmd_fill  in  1  fill bit for SHR and SHL.
- q  in  4  shift register output, fed back.
- sel  out  2  00 hold, 01 shift right (bit3 <= serial_in_right), 10 shift left (bit0 <= serial_in_left), 11 parallel load.
- serial_in_right  out  1  to the register.
- serial_in_left  out  1  to the register.
- parallel_in  out  4  to the register.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with `done`, for an illegal op.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- Reset (`clear`=1 at a clk edge): state goes to IDLE and the op/count/fill registers clear. All outputs become 0: `sel`=00, both serial outputs 0, `parallel_in`=0000, `busy`/`done`/`err`=0.
- `cmd_ready` = (state==IDLE). A command is accepted on an edge where `cmd_valid && cmd_ready`. On acceptance, op, count, data and fill are captured in registers.
- State after acceptance:
  - LOAD op: go to LOAD.
  - NOP, illegal op, or a shift/rotate op with count==0: go straight to DONE.
  - Otherwise: go to SHIFT with the remaining-step counter set to `cmd_count`.
- LOAD state:
  - Outputs: `sel`=11, `parallel_in`=captured data.
  - Next state: DONE.
  - `parallel_in` holds the last loaded value in every state until the next LOAD or reset.
- SHIFT state: drives `sel` and the serial inputs combinationally from the registered op and the current `q`:
  - SHR: `sel`=01, `serial_in_right`=fill.
  - SHL: `sel`=10, `serial_in_left`=fill.
  - ROR: `sel`=01, `serial_in_right`=q[0].
  - ROL: `sel`=10, `serial_in_left`=q[3].
  - ASR: `sel`=01, `serial_in_right`=q[3].
  - Each cycle the counter decrements. Leave for DONE on the edge where counter==1.
- The serial input not used by the current op is driven 0. `sel`=00 in IDLE and DONE.
- DONE state: `done`=1 for exactly one cycle, with `err`=1 if the op was 111. The next state is IDLE. `q` already holds the final result during DONE.
- Counts greater than 4 are legal:
  - SHR/SHL with count ≥4 yields all-fill.
  - ROR/ROL with count 4 returns the original value.
  - ASR saturates to all-sign.
- `cmd_valid` while busy is ignored; no command is lost, because `cmd_ready`=0.

## Timing
- Accept at edge E0.
- LOAD: `q` updates at E1, `done`=1 in the cycle E1–E2, `cmd_ready`=1 again after E2. Total 2 cycles per command.
- Shift with count N≥1: `q` steps at E1..EN, `done` in the cycle EN–E(N+1), `cmd_ready` after E(N+1). Total N+1 cycles.
- NOP, illegal op, or count 0: `done` in the cycle E0–E1; `q` unchanged.
- Back-to-back: the next command is accepted no earlier than the first IDLE cycle after DONE.
- Reset mid-command: `clear`=1 at any edge aborts the command. That same edge clears the register and returns the FSM to IDLE. No `done` pulse is issued for the aborted command. `cmd_ready`=1 in the following cycle once `clear` is low.
- `clear` dominates an accept that falls on the same edge; that command is dropped.

## Test plan
- Reset, then LOAD data=1011 → `sel`=11 for one cycle, `q`=1011 after E1, `done` pulse at E1–E2, `err`=0.
- From q=1011: SHR fill=1 count=2 → q=1101 then 1110; SHL fill=0 count=3 from 1011 → 0110, 1100, 1000; `done` arrives 1 cycle after the last step.
- From q=1011: ROR count=1 → 1101; ROL count=4 → 1011. ASR count=2 from 1000 → 1100, 1110.
- NOP, count=0 SHR, and op=111 → `q` unchanged, `done` the cycle after accept, `err`=1 only for 111.
- Assert `clear` during step 2 of SHL count=5 → `q`=0000, IDLE, no `done`; a following LOAD 0101 completes normally.
- Hold `cmd_valid` high continuously with alternating commands → each is accepted only while `cmd_ready`=1; `done` count equals the number of accepted commands.

Source files
------------

// File: rtl/usr_command_sequencer.sv
// Command sequencer for a 4-bit universal shift register: accepts load/shift/rotate/ASR
// commands over valid/ready and drives the register's control inputs cycle by cycle.
module usr_command_sequencer #(
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic [3:0]         cmd_data,
    input  logic               cmd_fill,
    input  logic [3:0]         q,
    output logic [1:0]         sel,
    output logic               serial_in_right,
    output logic               serial_in_left,
    output logic [3:0]         parallel_in,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_t             state, next_state;
    logic [2:0]         op_r;
    logic [COUNT_W-1:0] count_r;
    logic               fill_r;
    logic [3:0]         load_data;
    logic               accept;
    logic               is_shift_op;

    assign cmd_ready   = (state == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign is_shift_op = (cmd_op == OP_SHR) || (cmd_op == OP_SHL) || (cmd_op == OP_ROR) ||
                         (cmd_op == OP_ROL) || (cmd_op == OP_ASR);

    // load_data only changes on a LOAD so parallel_in keeps the last loaded value.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            op_r      <= OP_NOP;
            count_r   <= '0;
            fill_r    <= 1'b0;
            load_data <= 4'b0000;
        end else begin
            state <= next_state;
            if (accept) begin
                op_r    <= cmd_op;
                count_r <= cmd_count;
                fill_r  <= cmd_fill;
                if (cmd_op == OP_LOAD)
                    load_data <= cmd_data;
            end else if (state == SHIFT) begin
                count_r <= count_r - COUNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD)
                        next_state = LOAD;
                    else if (!is_shift_op || cmd_count == '0)
                        next_state = DONE;
                    else
                        next_state = SHIFT;
                end
            end
            LOAD:    next_state = DONE;
            SHIFT:   if (count_r == COUNT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        sel             = SEL_HOLD;
        serial_in_right = 1'b0;
        serial_in_left  = 1'b0;
        case (state)
            LOAD: sel = SEL_LOAD;
            SHIFT: begin
                case (op_r)
                    OP_SHR: begin sel = SEL_RIGHT; serial_in_right = fill_r; end
                    OP_SHL: begin sel = SEL_LEFT;  serial_in_left  = fill_r; end
                    OP_ROR: begin sel = SEL_RIGHT; serial_in_right = q[0];   end
                    OP_ROL: begin sel = SEL_LEFT;  serial_in_left  = q[3];   end
                    OP_ASR: begin sel = SEL_RIGHT; serial_in_right = q[3];   end
                    default: sel = SEL_HOLD;
                endcase
            end
            default: sel = SEL_HOLD;
        endcase
    end

    assign parallel_in = load_data;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign err         = (state == DONE) && (op_r == OP_ILL);

endmodule
